// File: rtl/pipe_sel_mux_pkg.sv
// Shared constants for the pipelined select mux and its two-entry skid buffer.
package pipe_sel_mux_pkg;

    // Largest channel count the selector is built for, and the select width it needs.
    localparam int MUX_N_MAX = 16;
    localparam int SEL_W     = $clog2(MUX_N_MAX);

    // Skid buffer state encodings (legacy-compatible numeric values).
    localparam logic [1:0] PSM_EMPTY = 2'd0;
    localparam logic [1:0] PSM_ONE   = 2'd1;
    localparam logic [1:0] PSM_FULL  = 2'd2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: main register M drives the output, skid register S
// catches the one beat that arrives while the consumer stalls. in_ready comes
// from the state register only, so there is no combinational path from
// out_ready back to in_ready.
//
// Handshake: a beat moves across a port on a rising clk edge when that port's
// valid and ready are both high. out_data is held stable while
// out_valid & !out_ready. Beats leave in the order they arrived.
module skid_buf2
    import pipe_sel_mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    state
);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [DW-1:0] m_q;
    logic [DW-1:0] s_q;
    logic          accept;

    // Ready is low while reset is held and whenever both entries are occupied.
    assign in_ready  = rst_n & (state_q != PSM_FULL);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == PSM_ONE) || (state_q == PSM_FULL);
    assign out_data  = m_q;
    assign state     = state_q;

    // Next-state decision from occupancy, incoming beat and consumer stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PSM_EMPTY: begin
                if (accept) state_d = PSM_ONE;
            end
            PSM_ONE: begin
                if (accept && !out_ready)      state_d = PSM_FULL;
                else if (!accept && out_ready) state_d = PSM_EMPTY;
                else                           state_d = PSM_ONE;
            end
            PSM_FULL: begin
                if (out_ready) state_d = PSM_ONE;
            end
            default: state_d = PSM_EMPTY;
        endcase
    end

    // State and storage update; reset discards both entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PSM_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                PSM_EMPTY: begin
                    if (accept) m_q <= in_data;
                end
                PSM_ONE: begin
                    if (accept && out_ready) m_q <= in_data;
                    else if (accept)         s_q <= in_data;
                end
                PSM_FULL: begin
                    if (out_ready) m_q <= s_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_sel_mux.sv
// N:1 datapath selector with one registered stage and a two-entry skid buffer.
// Out-of-range selects produce DEFAULT with the error flag set; the select that
// produced each beat travels alongside it.
module pipe_sel_mux
    import pipe_sel_mux_pkg::*;
#(
    parameter int           W       = 32,
    parameter int           N       = 5,
    parameter int           SW      = $clog2(N),
    parameter logic [W-1:0] DEFAULT = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [SW-1:0]  sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_err,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int DW = W + SW + 1;

    logic [W-1:0]  mux_data;
    logic          mux_err;
    logic [DW-1:0] buf_in;
    logic [DW-1:0] buf_out;
    logic [1:0]    buf_state;

    // Combinational channel pick; anything not matching a channel is out of range.
    always_comb begin
        mux_data = DEFAULT;
        mux_err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                mux_data = in_data[k*W +: W];
                mux_err  = 1'b0;
            end
        end
    end

    assign buf_in = {mux_err, sel, mux_data};

    skid_buf2 #(
        .DW(DW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (buf_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (buf_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .state    (buf_state)
    );

    assign {out_err, out_sel, out_data} = buf_out;

    // Outside reset, ready must track exactly "buffer not full".
    always @(posedge clk) begin
        if (rst_n) begin
            assert (in_ready == (buf_state != PSM_FULL))
                else $error("in_ready disagrees with buffer state");
        end
    end

endmodule
